// File: rtl/eta_mul_pkg.sv
// Shared types and constants for the sequential approximate multiplier.
//   state_t  : controller state (IDLE / RUN / DONE)
//   ACC_W    : accumulator and adder width (fixed at 16)
//   ETA_LO_W : width of the carry-free low segment inside eta_add16
package eta_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ACC_W    = 16;
  localparam int ETA_LO_W = 4;

endpackage

// File: rtl/eta_add16.sv
// 16-bit ETA-style approximate adder (combinational).
//   a, b : addends
//   sum  : approximate sum
//   cout : carry out of the exact upper segment
// The low ETA_LO_W bits use no carry chain: scanning from the segment MSB
// down, bits are XORed until the first position where both inputs are 1;
// that bit and every bit below it are forced to 1. The upper segment is an
// exact add with carry-in 0, so the low segment never carries upward.
module eta_add16
  import eta_mul_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             cout
);

  logic [ETA_LO_W-1:0]       lo;
  logic [ACC_W-ETA_LO_W-1:0] hi;
  logic                      hit;

  always_comb begin
    hit = 1'b0;
    lo  = '0;
    for (int i = ETA_LO_W - 1; i >= 0; i--) begin
      if (hit) begin
        lo[i] = 1'b1;
      end else if (a[i] && b[i]) begin
        lo[i] = 1'b1;
        hit   = 1'b1;
      end else begin
        lo[i] = a[i] ^ b[i];
      end
    end
  end

  always_comb begin
    {cout, hi} = {1'b0, a[ACC_W-1:ETA_LO_W]} + {1'b0, b[ACC_W-1:ETA_LO_W]};
  end

  assign sum = {hi, lo};

endmodule

// File: rtl/eta_seq_mul_ctrl.sv
// Sequential shift-and-add multiplier controller. One 16-bit adder is reused
// for WIDTH iterations to form an unsigned WIDTH x WIDTH product; a mode bit
// captured at accept selects the approximate eta_add16 or an exact add.
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   in_valid / in_ready  : operand handshake (op_a, op_b, approx_en)
//   out_valid / out_ready: result handshake (product, ovf)
//   product              : accumulator low 2*WIDTH bits
//   ovf                  : sticky adder carry-out over the operation
//   busy                 : high in RUN or DONE
//   dbg_state            : current controller state
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, holds its payload until that edge, and
// ready is a pure function of state (no combinational path from valid).
module eta_seq_mul_ctrl
  import eta_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  input  logic               approx_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               ovf,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               mode;
  logic               ovf_r;

  logic [ACC_W-1:0]   eta_sum;
  logic               eta_cout;
  logic [ACC_W-1:0]   ex_sum;
  logic               ex_cout;
  logic [ACC_W-1:0]   add_sum;
  logic               add_cout;
  logic               last_iter;

  // Adder inputs come straight from registers, so no comb loop is formed.
  eta_add16 u_eta_add16 (
    .a    (acc),
    .b    (a_sh),
    .sum  (eta_sum),
    .cout (eta_cout)
  );

  always_comb begin
    {ex_cout, ex_sum} = {1'b0, acc} + {1'b0, a_sh};
  end

  assign add_sum   = mode ? eta_sum  : ex_sum;
  assign add_cout  = mode ? eta_cout : ex_cout;
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = RUN;
      RUN:  if (last_iter) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    dbg_state = state;
  end

  // Datapath. acc and ovf are only touched on accept and in RUN, so they
  // stay stable through DONE backpressure and keep their values in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      cnt   <= '0;
      mode  <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= {{(ACC_W-WIDTH){1'b0}}, op_a};
            b_sh  <= op_b;
            acc   <= '0;
            cnt   <= '0;
            mode  <= approx_en;
            ovf_r <= 1'b0;
          end
        end
        RUN: begin
          if (b_sh[0]) begin
            acc   <= add_sum;
            ovf_r <= ovf_r | add_cout;
          end
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign product = acc[2*WIDTH-1:0];
  assign ovf     = ovf_r;

endmodule

// File: tb/tb_eta_seq_mul_ctrl.sv
// Self-checking bench for eta_seq_mul_ctrl (WIDTH=8).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// Latency is counted in rising edges from the accept edge (inclusive) to the
// edge after which out_valid is seen high.
module tb_eta_seq_mul_ctrl;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           approx_en;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           ovf;
  logic           busy;
  logic [1:0]     dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] exp_q[$];

  eta_seq_mul_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .approx_en (approx_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .ovf       (ovf),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // ETA add: low 4 bits carry-free, found via the highest position where
  // both addends are 1; upper 12 bits exact with no carry-in.
  function automatic logic [16:0] eta_ref(input logic [15:0] x, input logic [15:0] y);
    int lo_x, lo_y, both, k, mask, lo, hi;
    lo_x = int'(x) & 15;
    lo_y = int'(y) & 15;
    both = lo_x & lo_y;
    k = -1;
    for (int j = 0; j < 4; j++) if (both & (1 << j)) k = j;
    if (k >= 0) begin
      mask = (1 << (k + 1)) - 1;
      lo = ((lo_x ^ lo_y) & ~mask & 15) | mask;
    end else begin
      lo = lo_x ^ lo_y;
    end
    hi = (int'(x) >> 4) + (int'(y) >> 4);
    eta_ref = {hi[12], hi[11:0], lo[3:0]};
  endfunction

  function automatic logic [16:0] mul_ref(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] acc, ash;
    logic        o;
    logic [16:0] r;
    acc = '0;
    o   = 1'b0;
    ash = {8'd0, a};
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        r   = eta_ref(acc, ash);
        acc = r[15:0];
        o   = o | r[16];
      end
      ash = ash << 1;
    end
    mul_ref = {o, acc};
  endfunction

  // ---------------- driver ----------------
  // Presents one operation (in_ready assumed high), waits for out_valid and,
  // if out_ready is high, lets the handshake edge pass.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic m,
                        output logic [15:0] p, output logic o, output int lat);
    op_a = a;
    op_b = b;
    approx_en = m;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    p = product;
    o = ovf;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  logic [15:0] p;
  logic        o;
  int          lat;
  logic [16:0] r;
  logic [7:0]  ra, rb;
  logic [15:0] p_hold;
  logic        do_acc, do_out;
  logic [15:0] p_now;
  int          k, got;
  int          acc_cyc[4];
  logic [7:0]  ta[4];
  logic [7:0]  tb[4];

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    approx_en = 1'b0;
    out_ready = 1'b1;
    #23;

    // Reset values
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_product", product, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Exact 13 x 11
    run_op(8'd13, 8'd11, 1'b0, p, o, lat);
    check("ex13x11_p", p, 143);
    check("ex13x11_ovf", o, 0);
    check("ex13x11_lat", lat, 9);
    check("ex13x11_idle", in_ready, 1);

    // Exact corners
    run_op(8'd255, 8'd255, 1'b0, p, o, lat);
    check("ex255_p", p, 65025);
    check("ex255_ovf", o, 0);
    run_op(8'd0, 8'd200, 1'b0, p, o, lat);
    check("ex0_p", p, 0);
    check("ex0_lat", lat, 9);
    // product held in IDLE after handshake
    check("idle_hold_p", product, 0);

    run_op(8'd1, 8'd1, 1'b0, p, o, lat);
    check("ex1x1_p", p, 1);
    run_op(8'd128, 8'd128, 1'b0, p, o, lat);
    check("ex128_p", p, 16384);

    // Approx 13 x 11, hand-traced: 13 -> 31 -> 31 -> 127
    run_op(8'd13, 8'd11, 1'b1, p, o, lat);
    check("ap13x11_p", p, 127);
    check("ap13x11_ovf", o, 0);
    check("ap13x11_lat", lat, 9);

    // Approx sweep against the model
    for (int i = 0; i < 256; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      r  = mul_ref(ra, rb);
      exp_q.push_back(r[15:0]);
      run_op(ra, rb, 1'b1, p, o, lat);
      check("ap_sweep_p", p, exp_q.pop_front());
      check("ap_sweep_ovf", o, r[16]);
    end

    // Backpressure: 7 x 9 exact held for 5 cycles; in_valid ignored in DONE
    out_ready = 1'b0;
    run_op(8'd7, 8'd9, 1'b0, p, o, lat);
    check("bp_p", p, 63);
    check("bp_lat", lat, 9);
    in_valid = 1'b1;
    op_a = 8'd2;
    op_b = 8'd2;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", out_valid, 1);
      check("bp_product", product, 63);
      check("bp_ovf", ovf, 0);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    check("bp_release_p", product, 63);

    // Reset mid-op: 200 x 100, reset in RUN cycle 4
    op_a = 8'd200;
    op_b = 8'd100;
    approx_en = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("mid_busy_pre", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_product", product, 0);
    check("mid_rst_busy", busy, 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'd3, 8'd5, 1'b0, p, o, lat);
    check("post_rst_p", p, 15);

    // Back-to-back with in_valid and out_ready held high
    ta[0] = 8'd13;  tb[0] = 8'd11;
    ta[1] = 8'd255; tb[1] = 8'd2;
    ta[2] = 8'd100; tb[2] = 8'd100;
    ta[3] = 8'd6;   tb[3] = 8'd7;
    k = 0;
    got = 0;
    in_valid = 1'b1;
    approx_en = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 80 && got < 4; c++) begin
      if (k < 4) begin
        op_a = ta[k];
        op_b = tb[k];
      end else begin
        in_valid = 1'b0;
      end
      do_acc = in_valid && in_ready;
      do_out = out_valid;
      p_now  = product;
      @(posedge clk); #1;
      if (do_acc) begin
        acc_cyc[k] = c;
        exp_q.push_back(16'(ta[k]) * 16'(tb[k]));
        k++;
      end
      if (do_out) begin
        if (exp_q.size() > 0) check("b2b_p", p_now, exp_q.pop_front());
        else check("b2b_unexpected", 1, 0);
        got++;
      end
    end
    in_valid = 1'b0;
    check("b2b_accepts", k, 4);
    check("b2b_results", got, 4);
    check("b2b_q_empty", exp_q.size(), 0);
    for (int i = 1; i < 4; i++) begin
      if (i < k) check("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 10);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
